// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends a captured W-bit pattern MSB-first, reps times,
// with a programmable idle gap between copies. All outputs are registered.
module seq_tx #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 8,
  parameter int unsigned GW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [W-1:0]  pattern_i,
  input  logic [CW-1:0] reps_i,
  input  logic [GW-1:0] gap_i,
  output logic          dout_o,
  output logic          dvalid_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    st_o
);

  localparam int unsigned IW = $clog2(W);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StShift = 2'b01;
  localparam logic [1:0] StGap   = 2'b10;
  localparam logic [1:0] StDone  = 2'b11;

  localparam logic [IW-1:0] IdxTop = IW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [GW-1:0] gap_len_q, gap_len_d;
  logic [CW-1:0] rep_q, rep_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          dout_q, dout_d;
  logic          dvalid_q, dvalid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Outputs are computed from the current state and registered, so they trail st_o by one cycle.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    gap_len_d = gap_len_q;
    rep_d     = rep_q;
    gap_cnt_d = gap_cnt_q;
    idx_d     = idx_q;
    dout_d    = 1'b0;
    dvalid_d  = 1'b0;
    done_d    = 1'b0;
    busy_d    = (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          shadow_d  = pattern_i;
          gap_len_d = gap_i;
          rep_d     = reps_i;
          if (reps_i != '0) begin
            state_d = StShift;
            idx_d   = IdxTop;
          end else begin
            state_d = StDone;
          end
        end
      end
      StShift: begin
        dout_d   = shadow_q[idx_q];
        dvalid_d = 1'b1;
        if (idx_q != '0) begin
          idx_d = idx_q - IW'(1);
        end else begin
          if (rep_q != '0) rep_d = rep_q - CW'(1);
          if (rep_q <= CW'(1)) begin
            state_d = StDone;
          end else if (gap_len_q != '0) begin
            state_d   = StGap;
            gap_cnt_d = gap_len_q;
          end else begin
            idx_d = IdxTop;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GW'(1);
        if (gap_cnt_q <= GW'(1)) begin
          state_d = StShift;
          idx_d   = IdxTop;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort_i && (state_q != StIdle)) begin
      state_d  = StIdle;
      dout_d   = 1'b0;
      dvalid_d = 1'b0;
      done_d   = 1'b0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      gap_len_q <= '0;
      rep_q     <= '0;
      gap_cnt_q <= '0;
      idx_q     <= '0;
      dout_q    <= 1'b0;
      dvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      gap_len_q <= gap_len_d;
      rep_q     <= rep_d;
      gap_cnt_q <= gap_cnt_d;
      idx_q     <= idx_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dout_o   = dout_q;
  assign dvalid_o = dvalid_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign st_o     = state_q;

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: per-cycle expected outputs are queued at stimulus time
// and popped against the DUT, sampled on the falling clock edge.
module tb_seq_tx;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned GW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [W-1:0]  pattern_i = '0;
  logic [CW-1:0] reps_i = '0;
  logic [GW-1:0] gap_i = '0;
  logic          dout_o, dvalid_o, busy_o, done_o;
  logic [1:0]    st_o;

  // {dvalid, dout, busy, done}
  typedef logic [3:0] obs_t;
  obs_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  seq_tx #(.W(W), .CW(CW), .GW(GW)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .abort_i  (abort_i),
    .pattern_i(pattern_i),
    .reps_i   (reps_i),
    .gap_i    (gap_i),
    .dout_o   (dout_o),
    .dvalid_o (dvalid_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .st_o     (st_o)
  );

  function automatic void push_frame(logic [W-1:0] pat, int reps, int gap);
    for (int r = 0; r < reps; r++) begin
      for (int b = W - 1; b >= 0; b--) exp_q.push_back({1'b1, pat[b], 1'b1, 1'b0});
      if (r < reps - 1) for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endfunction

  task automatic test_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({dvalid_o, dout_o, busy_o, done_o} !== 4'b0000 || st_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold: got outs=%b st=%b expected outs=0000 st=00",
               {dvalid_o, dout_o, busy_o, done_o}, st_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({dvalid_o, dout_o, busy_o, done_o} !== 4'b0000 || st_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got outs=%b st=%b expected outs=0000 st=00",
               {dvalid_o, dout_o, busy_o, done_o}, st_o);
    end
  endtask

  // hold_start keeps start high until the done cycle, so it is presented during SHIFT and DONE.
  task automatic test_frame(string name, logic [W-1:0] pat, int reps, int gap, bit hold_start);
    obs_t o, e;
    int len;
    logic [1:0] exp_st;
    start_i   = 1'b1;
    pattern_i = pat;
    reps_i    = CW'(reps);
    gap_i     = GW'(gap);
    push_frame(pat, reps, gap);
    len    = exp_q.size();
    exp_st = (reps != 0) ? 2'b01 : 2'b11;
    @(negedge clk_i);
    if (!hold_start) start_i = 1'b0;
    pattern_i = ~pat;
    reps_i    = 8'hff;
    gap_i     = 4'h7;
    checks++;
    if ({dvalid_o, dout_o, busy_o, done_o} !== 4'b0000 || st_o !== exp_st) begin
      errors++;
      $display("FAIL %s cycle 0: got outs=%b st=%b expected outs=0000 st=%b",
               name, {dvalid_o, dout_o, busy_o, done_o}, st_o, exp_st);
    end
    for (int k = 1; k <= len; k++) begin
      @(negedge clk_i);
      e = exp_q.pop_front();
      o = {dvalid_o, dout_o, busy_o, done_o};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got {dvalid,dout,busy,done}=%b expected %b", name, k, o, e);
      end
      if (k == len - 1) start_i = 1'b0;
    end
  endtask

  task automatic test_abort();
    obs_t o, e;
    start_i   = 1'b1;
    pattern_i = 4'b1101;
    reps_i    = 8'd2;
    gap_i     = 4'd1;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1010);
    for (int i = 0; i < 5; i++) exp_q.push_back(4'b0000);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      e = exp_q.pop_front();
      o = {dvalid_o, dout_o, busy_o, done_o};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort cycle %0d: got {dvalid,dout,busy,done}=%b expected %b", k, o, e);
      end
      if (k == 4) begin
        abort_i = 1'b0;
        checks++;
        if (st_o !== 2'b00) begin
          errors++;
          $display("FAIL abort_state: got st=%b expected 00", st_o);
        end
      end
      if (k == 3) abort_i = 1'b1;
    end
    test_frame("abort_restart", 4'b0110, 1, 0, 1'b0);
  endtask

  task automatic test_abort_start_idle();
    start_i   = 1'b1;
    abort_i   = 1'b1;
    pattern_i = 4'b1111;
    reps_i    = 8'd1;
    gap_i     = 4'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    abort_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk_i);
      checks++;
      if ({dvalid_o, dout_o, busy_o, done_o} !== 4'b0000 || st_o !== 2'b00) begin
        errors++;
        $display("FAIL abort_with_start cycle %0d: got outs=%b st=%b expected outs=0000 st=00",
                 k, {dvalid_o, dout_o, busy_o, done_o}, st_o);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    start_i   = 1'b1;
    pattern_i = 4'b1010;
    reps_i    = 8'd2;
    gap_i     = 4'd3;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b0010);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      e = exp_q.pop_front();
      o = {dvalid_o, dout_o, busy_o, done_o};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_reset_pre cycle %0d: got %b expected %b", k, o, e);
      end
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({dvalid_o, dout_o, busy_o, done_o} !== 4'b0000 || st_o !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_immediate: got outs=%b st=%b expected outs=0000 st=00",
               {dvalid_o, dout_o, busy_o, done_o}, st_o);
    end
    start_i   = 1'b1;
    pattern_i = 4'b1111;
    reps_i    = 8'd1;
    @(posedge clk_i);
    #1;
    checks++;
    if ({dvalid_o, dout_o, busy_o, done_o} !== 4'b0000 || st_o !== 2'b00) begin
      errors++;
      $display("FAIL start_in_reset: got outs=%b st=%b expected outs=0000 st=00",
               {dvalid_o, dout_o, busy_o, done_o}, st_o);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    rst_ni  = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({dvalid_o, dout_o, busy_o, done_o} !== 4'b0000 || st_o !== 2'b00) begin
      errors++;
      $display("FAIL after_release_idle: got outs=%b st=%b expected outs=0000 st=00",
               {dvalid_o, dout_o, busy_o, done_o}, st_o);
    end
    test_frame("after_reset", 4'b1100, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] pat;
    for (int i = 0; i < 4; i++) begin
      pat = W'($urandom);
      test_frame("random", pat, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_frame("single", 4'b1011, 1, 0, 1'b0);
    test_frame("back_to_back", 4'b1111, 3, 0, 1'b1);
    test_frame("gap", 4'b1001, 2, 2, 1'b0);
    test_frame("zero_reps", 4'b1010, 0, 1, 1'b0);
    test_abort();
    test_abort_start_idle();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
